// File: rtl/ba_pkg.sv
// Shared types and constants for the Gen5 128b/130b block-alignment controller.
//   ba_state_e     : controller FSM states
//   EIEOS_ZERO/ONE : the two symbol values that make up an EIEOS
//   EIEOS_HALF_RUN : run length of each 0x00 / 0xFF group inside an EIEOS
package ba_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHunt,
        StSlipWait,
        StVerify,
        StAligned
    } ba_state_e;

    localparam logic [7:0]  EIEOS_ZERO     = 8'h00;
    localparam logic [7:0]  EIEOS_ONE      = 8'hFF;
    localparam int unsigned EIEOS_HALF_RUN = 4;

    // True for symbols that can legally appear in an EIEOS. A mismatch on such a
    // symbol means only the symbol phase is wrong, not the bit phase.
    function automatic logic is_eieos_sym(input logic [7:0] sym);
        return (sym == EIEOS_ZERO) || (sym == EIEOS_ONE);
    endfunction

    // Expected bit value of EIEOS symbol idx (0 for the 0x00 runs, 1 for 0xFF).
    function automatic logic eieos_bit(input int unsigned idx);
        return ((idx / EIEOS_HALF_RUN) % 2) != 0;
    endfunction

endpackage

// File: rtl/ba_block_counter.sv
// Symbol index counter, 0..MODULUS-1 with wrap. Used as the EIEOS symbol index
// while verifying and as the block symbol index once aligned.
//   rx_clk, rx_rst : clock, async active-low reset
//   clr_i          : synchronous clear to 0 (wins over inc_i)
//   inc_i          : advance by one (valid-gated by the caller)
//   count_o        : registered index
//   count_next_o   : index that will be registered on the next edge
module ba_block_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 16
) (
    input  logic             rx_clk,
    input  logic             rx_rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o,
    output logic [WIDTH-1:0] count_next_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = (count_q == WIDTH'(MODULUS - 1)) ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge rx_clk or negedge rx_rst) begin
        if (!rx_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign count_next_o = count_d;

endmodule

// File: rtl/ba_align_ctrl.sv
// Per-lane Gen5 block-alignment controller (rx_clk domain). Hunts for the EIEOS
// pattern, drives the lane's EIEOS expected-flag generator, requests bit slips
// from the deserializer until the pattern locks, then marks 16-symbol blocks.
//   rx_clk, rx_rst   : recovered clock, async active-low reset
//   soft_rst         : sync active-high reset, highest priority
//   ba_enable        : 128b/130b alignment enabled by the LTSSM
//   realign_req      : sync-header error, forces a re-hunt
//   rx_symbol(_valid): deserialized symbol and qualifier
//   exp_flag         : generator expected bit (registered, 1-cycle latency)
//   flag_en, symbols_count, rst_flag : generator control
//   slip_req         : one-cycle bit-slip request
//   block_aligned    : alignment achieved (level)
//   block_start      : symbol 0 of an aligned block (pulse)
//   align_err        : EIEOS verify failure (pulse)
module ba_align_ctrl
    import ba_pkg::*;
#(
    parameter int unsigned SYMBOL_COUNT_WIDTH = 4,
    parameter int unsigned EIEOS_SYMS         = 16,
    parameter int unsigned SLIP_WAIT          = 4,
    parameter int unsigned SLIP_WAIT_W        = 3
) (
    input  logic                          rx_clk,
    input  logic                          rx_rst,
    input  logic                          soft_rst,
    input  logic                          ba_enable,
    input  logic                          realign_req,
    input  logic [7:0]                    rx_symbol,
    input  logic                          rx_symbol_valid,
    input  logic                          exp_flag,
    output logic                          flag_en,
    output logic [SYMBOL_COUNT_WIDTH-1:0] symbols_count,
    output logic                          rst_flag,
    output logic                          slip_req,
    output logic                          block_aligned,
    output logic                          block_start,
    output logic                          align_err
);

    ba_state_e               state_q, state_d;
    logic [SLIP_WAIT_W-1:0]  wait_q, wait_d;
    logic [SYMBOL_COUNT_WIDTH-1:0] idx_q, idx_d;
    logic                    idx_clr, idx_inc;
    logic                    rst_flag_c;

    ba_block_counter #(
        .WIDTH   (SYMBOL_COUNT_WIDTH),
        .MODULUS (EIEOS_SYMS)
    ) u_idx (
        .rx_clk       (rx_clk),
        .rx_rst       (rx_rst),
        .clr_i        (idx_clr),
        .inc_i        (idx_inc),
        .count_o      (idx_q),
        .count_next_o (idx_d)
    );

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        idx_clr     = 1'b0;
        idx_inc     = 1'b0;
        flag_en     = 1'b0;
        rst_flag_c  = 1'b0;
        slip_req    = 1'b0;
        block_start = 1'b0;
        align_err   = 1'b0;

        if (soft_rst) begin
            // Every output stays 0 while the soft reset is held.
            state_d = StIdle;
            wait_d  = '0;
            idx_clr = 1'b1;
        end else if (!ba_enable) begin
            state_d    = StIdle;
            wait_d     = '0;
            idx_clr    = 1'b1;
            rst_flag_c = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    rst_flag_c = 1'b1;
                    idx_clr    = 1'b1;
                    state_d    = StHunt;
                end
                StHunt: begin
                    if (rx_symbol_valid) begin
                        if (rx_symbol == EIEOS_ZERO) begin
                            // Symbol 0 matched; index 0 -> 1 and load the generator.
                            flag_en = 1'b1;
                            idx_inc = 1'b1;
                            state_d = StVerify;
                        end else if (rx_symbol != EIEOS_ONE) begin
                            slip_req = 1'b1;
                            wait_d   = '0;
                            state_d  = StSlipWait;
                        end
                    end
                end
                StSlipWait: begin
                    // Deserializer settle window; data is ignored, valid or not.
                    if (wait_q == SLIP_WAIT_W'(SLIP_WAIT - 1)) begin
                        wait_d  = '0;
                        state_d = StHunt;
                    end else begin
                        wait_d = wait_q + SLIP_WAIT_W'(1);
                    end
                end
                StVerify: begin
                    if (rx_symbol_valid) begin
                        if (rx_symbol == {8{exp_flag}}) begin
                            flag_en = 1'b1;
                            idx_inc = 1'b1;
                            if (idx_q == SYMBOL_COUNT_WIDTH'(EIEOS_SYMS - 1)) begin
                                state_d = StAligned;
                            end
                        end else begin
                            align_err  = 1'b1;
                            rst_flag_c = 1'b1;
                            idx_clr    = 1'b1;
                            if (is_eieos_sym(rx_symbol)) begin
                                // Bit phase is fine, only the symbol phase is off.
                                state_d = StHunt;
                            end else begin
                                slip_req = 1'b1;
                                wait_d   = '0;
                                state_d  = StSlipWait;
                            end
                        end
                    end
                end
                StAligned: begin
                    if (realign_req) begin
                        rst_flag_c = 1'b1;
                        idx_clr    = 1'b1;
                        state_d    = StHunt;
                    end else if (rx_symbol_valid) begin
                        idx_inc     = 1'b1;
                        block_start = (idx_q == '0);
                    end
                end
                default: begin
                    state_d = StIdle;
                    idx_clr = 1'b1;
                    wait_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge rx_clk or negedge rx_rst) begin
        if (!rx_rst) begin
            state_q <= StIdle;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // IDLE requests a generator clear, but not while a reset is being applied.
    assign rst_flag      = rst_flag_c & rx_rst;
    assign block_aligned = (state_q == StAligned) && !soft_rst;
    // Next expected EIEOS symbol; meaningless once aligned, so held at 0 there.
    assign symbols_count = (state_q == StAligned) ? '0 : idx_d;

endmodule

// File: tb/tb_ba_align_ctrl.sv
module tb_ba_align_ctrl;

    logic       rx_clk = 1'b0;
    logic       rx_rst;
    logic       soft_rst;
    logic       ba_enable;
    logic       realign_req;
    logic [7:0] rx_symbol;
    logic       rx_symbol_valid;
    logic       exp_flag;
    logic       flag_en;
    logic [3:0] symbols_count;
    logic       rst_flag;
    logic       slip_req;
    logic       block_aligned;
    logic       block_start;
    logic       align_err;

    int checks = 0;
    int errors = 0;

    always #5 rx_clk = ~rx_clk;

    ba_align_ctrl dut (
        .rx_clk          (rx_clk),
        .rx_rst          (rx_rst),
        .soft_rst        (soft_rst),
        .ba_enable       (ba_enable),
        .realign_req     (realign_req),
        .rx_symbol       (rx_symbol),
        .rx_symbol_valid (rx_symbol_valid),
        .exp_flag        (exp_flag),
        .flag_en         (flag_en),
        .symbols_count   (symbols_count),
        .rst_flag        (rst_flag),
        .slip_req        (slip_req),
        .block_aligned   (block_aligned),
        .block_start     (block_start),
        .align_err       (align_err)
    );

    // Lane-level EIEOS expected-flag generator model.
    logic gen_q;
    always_ff @(posedge rx_clk or negedge rx_rst) begin
        if (!rx_rst)       gen_q <= 1'b0;
        else if (rst_flag) gen_q <= 1'b0;
        else if (flag_en)  gen_q <= symbols_count[2];
    end
    assign exp_flag = gen_q;

    typedef struct {
        logic       valid;
        logic [7:0] sym;
        logic       en;
        logic       fe;
        logic [3:0] cnt;
        logic       rf;
        logic       slip;
        logic       al;
        logic       bs;
        logic       ae;
    } vec_t;

    vec_t vecs[$];

    task automatic push(input logic v, input logic [7:0] s, input logic en, input logic fe,
                        input int cnt, input logic rf, input logic sl, input logic al,
                        input logic bs, input logic ae);
        vec_t r;
        r.valid = v;  r.sym = s;  r.en = en;  r.fe = fe;  r.cnt = 4'(cnt);
        r.rf = rf;    r.slip = sl; r.al = al;  r.bs = bs;  r.ae = ae;
        vecs.push_back(r);
    endtask

    function automatic logic [7:0] eieos(input int i);
        return (((i / 4) % 2) != 0) ? 8'hFF : 8'h00;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic v, input logic [7:0] s, input logic en, input logic rr,
                         input logic sr);
        rx_symbol_valid = v;
        rx_symbol       = s;
        ba_enable       = en;
        realign_req     = rr;
        soft_rst        = sr;
        #1;
    endtask

    task automatic tick();
        @(negedge rx_clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " flag_en"}, flag_en, 0);
        chk({tag, " symbols_count"}, symbols_count, 0);
        chk({tag, " rst_flag"}, rst_flag, 0);
        chk({tag, " slip_req"}, slip_req, 0);
        chk({tag, " block_aligned"}, block_aligned, 0);
        chk({tag, " block_start"}, block_start, 0);
        chk({tag, " align_err"}, align_err, 0);
    endtask

    task automatic go_idle();
        apply(0, 8'h00, 0, 0, 0);
        tick();
        apply(0, 8'h00, 0, 0, 0);
        tick();
    endtask

    // From HUNT with a cleared generator: one clean 16-symbol EIEOS, then one data symbol.
    task automatic lock_eieos(input string tag);
        for (int i = 0; i < 16; i++) begin
            apply(1, eieos(i), 1, 0, 0);
            chk($sformatf("%s sym%0d slip_req", tag, i), slip_req, 0);
            chk($sformatf("%s sym%0d flag_en", tag, i), flag_en, 1);
            tick();
        end
        apply(1, 8'h5C, 1, 0, 0);
        chk({tag, " block_aligned"}, block_aligned, 1);
        chk({tag, " block_start"}, block_start, 1);
        tick();
    endtask

    initial begin
        rx_rst = 1'b1;
        soft_rst = 1'b0; ba_enable = 1'b0; realign_req = 1'b0;
        rx_symbol = 8'h00; rx_symbol_valid = 1'b0;
        #2 rx_rst = 1'b0;

        // ---- vector table --------------------------------------------------
        // Clean EIEOS from IDLE, lock, 17 data symbols (block_start at 0 and 16).
        push(0, 8'h00, 1, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) push(1, eieos(i), 1, 1, (i + 1) % 16, 0, 0, 0, 0, 0);
        for (int i = 0; i < 17; i++) push(1, 8'(8'h10 + i), 1, 0, 0, 0, 0, 1, (i % 16) == 0, 0);
        // ba_enable low: block_aligned drops on the next edge.
        push(1, 8'h5A, 0, 0, 0, 1, 0, 1, 0, 0);
        push(0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 0);
        // Stream starts at EIEOS symbol 2; fails at index 2 without a slip.
        push(0, 8'h00, 1, 0, 0, 1, 0, 0, 0, 0);
        push(1, 8'h00, 1, 1, 1, 0, 0, 0, 0, 0);
        push(1, 8'h00, 1, 1, 2, 0, 0, 0, 0, 0);
        push(1, 8'hFF, 1, 0, 0, 1, 0, 0, 0, 1);
        for (int i = 5; i < 8; i++) push(1, 8'hFF, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) push(1, eieos(i + 8), 1, 1, (i + 1) % 16, 0, 0, 0, 0, 0);
        push(1, 8'h21, 1, 0, 0, 0, 0, 1, 1, 0);
        push(1, 8'h22, 1, 0, 0, 0, 0, 1, 0, 0);
        push(1, 8'h23, 0, 0, 0, 1, 0, 1, 0, 0);
        push(0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 0);
        // Valid gap of 3 cycles between symbols 5 and 6: index holds at 6.
        push(0, 8'h00, 1, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) push(1, eieos(i), 1, 1, i + 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) push(0, 8'h3C, 1, 0, 6, 0, 0, 0, 0, 0);
        for (int i = 6; i < 16; i++) push(1, eieos(i), 1, 1, (i + 1) % 16, 0, 0, 0, 0, 0);
        push(1, 8'h44, 1, 0, 0, 0, 0, 1, 1, 0);

        // ---- async reset state ---------------------------------------------
        tick();
        tick();
        chk_all_zero("reset");
        rx_rst = 1'b1;

        // ---- apply table ---------------------------------------------------
        for (int n = 0; n < vecs.size(); n++) begin
            apply(vecs[n].valid, vecs[n].sym, vecs[n].en, 0, 0);
            chk($sformatf("row%0d flag_en", n), flag_en, vecs[n].fe);
            chk($sformatf("row%0d symbols_count", n), symbols_count, vecs[n].cnt);
            chk($sformatf("row%0d rst_flag", n), rst_flag, vecs[n].rf);
            chk($sformatf("row%0d slip_req", n), slip_req, vecs[n].slip);
            chk($sformatf("row%0d block_aligned", n), block_aligned, vecs[n].al);
            chk($sformatf("row%0d block_start", n), block_start, vecs[n].bs);
            chk($sformatf("row%0d align_err", n), align_err, vecs[n].ae);
            tick();
        end

        // ---- bit offset: slips and 4-cycle ignore windows --------------------
        go_idle();
        apply(0, 8'h00, 1, 0, 0);
        chk("slip idle rst_flag", rst_flag, 1);
        tick();
        apply(1, 8'h1F, 1, 0, 0);
        chk("slip1 slip_req", slip_req, 1);
        chk("slip1 flag_en", flag_en, 0);
        tick();
        for (int w = 0; w < 4; w++) begin
            apply(w != 1, 8'h1F, 1, 0, 0);
            chk($sformatf("wait1.%0d slip_req", w), slip_req, 0);
            chk($sformatf("wait1.%0d align_err", w), align_err, 0);
            tick();
        end
        apply(1, 8'h3E, 1, 0, 0);
        chk("slip2 slip_req", slip_req, 1);
        tick();
        for (int w = 0; w < 4; w++) begin
            apply(0, 8'h00, 1, 0, 0);
            chk($sformatf("wait2.%0d slip_req", w), slip_req, 0);
            tick();
        end
        apply(1, 8'h00, 1, 0, 0);
        chk("hunt sym0 flag_en", flag_en, 1);
        chk("hunt sym0 symbols_count", symbols_count, 1);
        tick();
        apply(1, 8'h1F, 1, 0, 0);
        chk("verify mixed align_err", align_err, 1);
        chk("verify mixed slip_req", slip_req, 1);
        chk("verify mixed rst_flag", rst_flag, 1);
        tick();
        for (int w = 0; w < 4; w++) begin
            apply(1, 8'h00, 1, 0, 0);
            chk($sformatf("wait3.%0d flag_en", w), flag_en, 0);
            chk($sformatf("wait3.%0d slip_req", w), slip_req, 0);
            tick();
        end
        lock_eieos("slip lock");

        // ---- realign_req in ALIGNED ------------------------------------------
        apply(1, 8'h77, 1, 1, 0);
        chk("realign rst_flag", rst_flag, 1);
        chk("realign block_start", block_start, 0);
        chk("realign block_aligned", block_aligned, 1);
        tick();
        apply(0, 8'h00, 1, 0, 0);
        chk("realign+1 block_aligned", block_aligned, 0);
        chk("realign+1 rst_flag", rst_flag, 0);
        tick();
        lock_eieos("relock");

        // ---- soft_rst at VERIFY index 9 ----------------------------------------
        go_idle();
        apply(0, 8'h00, 1, 0, 0);
        tick();
        for (int i = 0; i < 9; i++) begin
            apply(1, eieos(i), 1, 0, 0);
            tick();
        end
        apply(1, 8'h00, 1, 0, 1);
        chk_all_zero("soft_rst at idx9");
        tick();
        apply(1, 8'h00, 1, 0, 1);
        chk_all_zero("soft_rst held");
        tick();
        apply(1, 8'h00, 1, 0, 0);
        chk("post soft_rst idle rst_flag", rst_flag, 1);
        chk("post soft_rst idle flag_en", flag_en, 0);
        tick();
        apply(1, 8'h00, 1, 0, 0);
        chk("post soft_rst hunt flag_en", flag_en, 1);
        chk("post soft_rst hunt symbols_count", symbols_count, 1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
